// File: rtl/i2s_capture.sv
`timescale 1ns/1ps
// i2s_capture: I2S MEMS microphone front end; deserialises the left slot, decimates,
// reduces to 16-bit PCM and writes it MSB byte first into a byte FIFO.
// Optional macro I2S_CAPTURE_ROUND_EN: round half up with positive saturation (+1 cycle).
module i2s_capture #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int SCK_FREQ      = 1_562_500,
  parameter int DATA_SIZE     = 24,
  parameter int REDUCE_FACTOR = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        i2s_clk,
  output logic        i2s_ws,
  input  logic        i2s_sd,
  output logic [15:0] pcm_out,
  output logic        pcm_ready,
  output logic [7:0]  fifo_wr_data,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic [15:0] drop_count
);

  localparam int DIV   = CLK_FREQ / (2 * SCK_FREQ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEC_W = (REDUCE_FACTOR > 1) ? $clog2(REDUCE_FACTOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(REDUCE_FACTOR - 1);
  localparam logic [5:0]       LAST_BIT = 6'(DATA_SIZE);

  typedef enum logic [1:0] {IDLE, HI, LO} emit_state_t;

  logic [DIV_W-1:0]     div_cnt;
  logic [5:0]           bit_cnt;
  logic [5:0]           bit_cnt_next;
  logic [DEC_W-1:0]     dec_cnt;
  logic [DATA_SIZE-1:0] shift_reg;
  logic                 keep_pend;
  logic                 sck_toggle, rise, fall, capture, sample_done;

  assign sck_toggle   = (div_cnt == DIV_LAST);
  assign rise         = sck_toggle & ~i2s_clk;
  assign fall         = sck_toggle &  i2s_clk;
  assign bit_cnt_next = bit_cnt + 6'd1;
  assign capture      = rise && !i2s_ws && (bit_cnt >= 6'd1) && (bit_cnt <= LAST_BIT);
  assign sample_done  = rise && !i2s_ws && (bit_cnt == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      i2s_clk   <= 1'b0;
      i2s_ws    <= 1'b0;
      bit_cnt   <= '0;
      dec_cnt   <= '0;
      shift_reg <= '0;
      keep_pend <= 1'b0;
    end else begin
      div_cnt   <= sck_toggle ? '0 : div_cnt + 1'b1;
      keep_pend <= 1'b0;
      if (sck_toggle) i2s_clk <= ~i2s_clk;
      if (fall) begin
        bit_cnt <= bit_cnt_next;
        i2s_ws  <= bit_cnt_next[5];
      end
      if (capture) shift_reg <= {shift_reg[DATA_SIZE-2:0], i2s_sd};
      // The completing bit lands in shift_reg on this edge; the word is taken a cycle later.
      if (sample_done) begin
        keep_pend <= (dec_cnt == '0);
        dec_cnt   <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
      end
    end
  end

  logic [15:0] trunc_word;
  logic        kept_valid;
  logic [15:0] kept_word;

  assign trunc_word = shift_reg[DATA_SIZE-1 -: 16];

`ifdef I2S_CAPTURE_ROUND_EN
  localparam int RB = (DATA_SIZE > 16) ? DATA_SIZE - 17 : 0;

  logic        round_bit;
  logic [15:0] round_word;
  logic        round_valid;
  logic [15:0] round_q;

  assign round_bit = (DATA_SIZE > 16) ? shift_reg[RB] : 1'b0;

  // NOTE: assign a default first so always_comb never infers a latch.
  always_comb begin
    round_word = trunc_word + {15'd0, round_bit};
    if (trunc_word == 16'h7FFF && round_bit) round_word = 16'h7FFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_valid <= 1'b0;
      round_q     <= '0;
    end else begin
      round_valid <= keep_pend;
      round_q     <= round_word;
    end
  end

  assign kept_valid = round_valid;
  assign kept_word  = round_q;
`else
  assign kept_valid = keep_pend;
  assign kept_word  = trunc_word;
`endif

  emit_state_t state;
  logic [15:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_q       <= '0;
      pcm_out      <= '0;
      pcm_ready    <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      drop_count   <= '0;
    end else begin
      pcm_ready  <= kept_valid;
      fifo_wr_en <= 1'b0;
      if (kept_valid) pcm_out <= kept_word;
      case (state)
        IDLE: if (kept_valid && !fifo_full) begin
          word_q <= kept_word;
          state  <= HI;
        end
        HI: begin
          fifo_wr_data <= word_q[15:8];
          fifo_wr_en   <= 1'b1;
          state        <= LO;
        end
        LO: if (!fifo_full) begin
          fifo_wr_data <= word_q[7:0];
          fifo_wr_en   <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A word is lost when the emitter is mid-pair or the FIFO cannot take a new pair.
      if (kept_valid && (state != IDLE || fifo_full) && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_i2s_capture.sv
`timescale 1ns/1ps
// tb_i2s_capture: randomized microphone stimulus checked every cycle against a
// frame-level behavioural model, plus literal expectations for key scenarios.
module tb_i2s_capture;

  localparam int DS = 24;
  localparam int R  = 2;
`ifdef I2S_CAPTURE_ROUND_EN
  localparam int          LAT     = 1;
  localparam logic [15:0] ABC_PCM = 16'hABCE;
  localparam logic [15:0] V1_PCM  = 16'h1235;
  localparam logic [15:0] V3_PCM  = 16'h0000;
`else
  localparam int          LAT     = 0;
  localparam logic [15:0] ABC_PCM = 16'hABCD;
  localparam logic [15:0] V1_PCM  = 16'h1234;
  localparam logic [15:0] V3_PCM  = 16'hFFFF;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i2s_clk, i2s_ws, pcm_ready, fifo_wr_en;
  logic i2s_sd = 1'b0;
  logic fifo_full = 1'b0;
  logic [15:0] pcm_out, drop_count;
  logic [7:0]  fifo_wr_data;

  logic i2s_clk2, i2s_ws2, pcm_ready2, fifo_wr_en2;
  logic i2s_sd2 = 1'b0;
  logic fifo_full2 = 1'b0;
  logic [15:0] pcm_out2, drop_count2;
  logic [7:0]  fifo_wr_data2;

  always #5 clk = ~clk;

  i2s_capture dut (
    .clk(clk), .rst_n(rst_n), .i2s_clk(i2s_clk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .pcm_out(pcm_out), .pcm_ready(pcm_ready), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .drop_count(drop_count)
  );

  i2s_capture #(.DATA_SIZE(16), .REDUCE_FACTOR(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i2s_clk(i2s_clk2), .i2s_ws(i2s_ws2), .i2s_sd(i2s_sd2),
    .pcm_out(pcm_out2), .pcm_ready(pcm_ready2), .fifo_wr_data(fifo_wr_data2),
    .fifo_wr_en(fifo_wr_en2), .fifo_full(fifo_full2), .drop_count(drop_count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Stimulus controls
  int          left_mode = 0;           // 0: fixed 0xABCDEF, 1: random
  bit          ff_mode   = 0;           // 1: random fifo_full
  logic [23:0] left_q[$];               // values forced onto upcoming kept frames
  logic [23:0] right_val = 24'h111111;
  logic [15:0] left2     = 16'h8001;
  logic [23:0] cur_left  = '0;

  always @(negedge clk) if (ff_mode) fifo_full = ($urandom_range(0, 2) == 0);

  // Reference model state (n = clock edges since reset release)
  int          n = 0;
  int          rdy_edge = 0;
  int          exp_drops = 0;
  bit          ff, busy, hi_next, rdy_pend, exp_rdy, exp_we;
  logic [15:0] exp_pcm = '0, rdy_word = '0;
  logic [7:0]  exp_wd = '0;
  logic [7:0]  byte_q[$];

  function automatic logic [15:0] reduce(input logic [23:0] v);
    int s;
    s = int'($signed(v[23:8]));
`ifdef I2S_CAPTURE_ROUND_EN
    s = s + int'(v[7]);
    if (s > 32767) s = 32767;
`endif
    return 16'(s);
  endfunction

  // Microphone: set the bit sampled by SCK rise k (bit position k%64 of frame k/64).
  task automatic drive_sd(input int k);
    int p, f;
    p = k % 64;
    f = k / 64;
    if (p == 1) begin
      if (f % R == 0 && left_q.size() > 0) cur_left = left_q.pop_front();
      else if (left_mode == 0)             cur_left = 24'hABCDEF;
      else                                 cur_left = 24'($urandom);
    end
    if (p >= 1 && p <= DS)       i2s_sd = cur_left[DS-p];
    else if (p >= 33 && p <= 56) i2s_sd = right_val[56-p];
    else                         i2s_sd = 1'($urandom);
    if (p >= 1 && p <= 16) i2s_sd2 = left2[16-p];
    else                   i2s_sd2 = 1'($urandom);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; byte_q.delete(); hi_next = 0; rdy_pend = 0;
      exp_rdy = 0; exp_we = 0; exp_pcm = '0; exp_wd = '0; exp_drops = 0;
      drive_sd(0);
      #1;
      check("rst_i2s_clk", i2s_clk, 0);
      check("rst_i2s_ws", i2s_ws, 0);
      check("rst_pcm_out", pcm_out, 0);
      check("rst_pcm_ready", pcm_ready, 0);
      check("rst_fifo_wr_en", fifo_wr_en, 0);
      check("rst_fifo_wr_data", fifo_wr_data, 0);
      check("rst_drop_count", drop_count, 0);
    end else begin
      ff = fifo_full;
      n++;
      // Completing rise of a left sample: bit position DS of the frame.
      if (n >= 8 && (n - 8) % 16 == 0) begin
        int k;
        k = (n - 8) / 16;
        if (k % 64 == DS && (k / 64) % R == 0) begin
          rdy_pend = 1;
          rdy_edge = n + 1 + LAT;
          rdy_word = reduce(cur_left);
        end
      end
      exp_rdy = 0;
      exp_we  = 0;
      busy = (byte_q.size() != 0);
      if (busy && (hi_next || !ff)) begin
        exp_wd  = byte_q.pop_front();
        exp_we  = 1;
        hi_next = 0;
      end
      if (rdy_pend && n == rdy_edge) begin
        rdy_pend = 0;
        exp_rdy  = 1;
        exp_pcm  = rdy_word;
        if (busy || ff) begin
          if (exp_drops < 65535) exp_drops++;
        end else begin
          byte_q.push_back(rdy_word[15:8]);
          byte_q.push_back(rdy_word[7:0]);
          hi_next = 1;
        end
      end
      #1;
      check("i2s_clk", i2s_clk, (n / 8) % 2);
      check("i2s_ws", i2s_ws, ((n / 16) % 64) >= 32);
      check("pcm_ready", pcm_ready, exp_rdy);
      check("pcm_out", pcm_out, exp_pcm);
      check("fifo_wr_en", fifo_wr_en, exp_we);
      if (exp_we) check("fifo_wr_data", fifo_wr_data, exp_wd);
      check("drop_count", drop_count, exp_drops);
      if (n % 16 == 0) drive_sd(n / 16);
    end
  end

  // Second instance: 16-bit, no decimation, constant 0x8001 every frame.
  int pcm2_cnt = 0;
  bit b2_idx = 0;
  int wr_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) b2_idx = 0;
    else begin
      #1;
      if (fifo_wr_en) wr_cnt++;
      if (pcm_ready2) begin
        pcm2_cnt++;
        check("pcm_out2", pcm_out2, 16'h8001);
        check("drop_count2", drop_count2, 0);
      end
      if (fifo_wr_en2) begin
        check("fifo_byte2", fifo_wr_data2, b2_idx ? 8'h01 : 8'h80);
        b2_idx = !b2_idx;
      end
    end
  end

  task automatic wait_ready(input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (pcm_ready) begin ok = 1; break; end
    end
    check("pcm_ready_seen", ok, 1);
  endtask

  function automatic logic pick(input int sel);
    return (sel != 0) ? i2s_ws : i2s_clk;
  endfunction

  // Length in cycles of the first complete run of level 'want' on the selected signal.
  task automatic run_length(input int sel, input logic want, input int max_cyc, output int len);
    logic prv, cur;
    bit seen;
    seen = 0; len = 0;
    @(posedge clk); #2; prv = pick(sel);
    for (int i = 0; i < 2 * max_cyc; i++) begin
      @(posedge clk); #2; cur = pick(sel);
      if (cur !== prv) begin
        if (seen) return;
        if (cur === want) begin seen = 1; len = 1; end
      end else if (seen) len++;
      prv = cur;
    end
    len = -1;
  endtask

  task automatic check_pair(input string tag, input logic [15:0] w);
    @(posedge clk); #2;
    check({tag, "_hi_en"}, fifo_wr_en, 1);
    check({tag, "_hi_byte"}, fifo_wr_data, w[15:8]);
    @(posedge clk); #2;
    check({tag, "_lo_en"}, fifo_wr_en, 1);
    check({tag, "_lo_byte"}, fifo_wr_data, w[7:0]);
    @(posedge clk); #2;
    check({tag, "_no_extra"}, fifo_wr_en, 0);
  endtask

  initial begin
    int len, wr_before;
    repeat (3) @(negedge clk);
    check("hold_pcm_out", pcm_out, 0);
    check("hold_drop_count", drop_count, 0);
    rst_n = 1'b1;

    // Fixed data: first kept sample latency and byte pair
    wait_ready(600);
    check("first_ready_edge", n, 393 + LAT);
    check("first_pcm", pcm_out, ABC_PCM);
    check_pair("first", ABC_PCM);

    // Clock shape
    run_length(0, 1'b1, 40, len);   check("sck_high_len", len, 8);
    run_length(0, 1'b0, 40, len);   check("sck_low_len", len, 8);
    run_length(1, 1'b1, 1100, len); check("ws_high_len", len, 512);

    // FIFO full across three kept samples
    fifo_full = 1'b1;
    wr_before = wr_cnt;
    repeat (3) wait_ready(2200);
    fifo_full = 1'b0;
    check("full_drops", drop_count, 3);
    check("full_no_writes", wr_cnt - wr_before, 0);

    // FIFO full only while the low byte is pending
    wait_ready(2200);
    @(posedge clk); #2;
    check("lo_hold_hi_en", fifo_wr_en, 1);
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("lo_hold_idle", fifo_wr_en, 0);
    end
    fifo_full = 1'b0;
    @(posedge clk); #2;
    check("lo_release_en", fifo_wr_en, 1);
    check("lo_release_byte", fifo_wr_data, ABC_PCM[7:0]);
    @(posedge clk); #2;
    check("lo_no_extra", fifo_wr_en, 0);

    // Reduction boundary values
    left_q.push_back(24'h123480);
    left_q.push_back(24'h7FFF80);
    left_q.push_back(24'hFFFF80);
    wait_ready(4200); check("val_123480", pcm_out, V1_PCM);
    wait_ready(2200); check("val_7fff80", pcm_out, 16'h7FFF);
    wait_ready(2200); check("val_ffff80", pcm_out, V3_PCM);

    // Random data with random FIFO back-pressure
    left_mode = 1;
    ff_mode = 1;
    repeat (6) wait_ready(2200);
    ff_mode = 0;
    fifo_full = 1'b0;
    left_mode = 0;

    // Reset mid-frame
    repeat (700) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("midframe_rst_ready", pcm_ready, 0);
    check("midframe_rst_clk", i2s_clk, 0);
    check("midframe_rst_drops", drop_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(600);
    check("midframe_ready_edge", n, 393 + LAT);
    check("midframe_pcm", pcm_out, ABC_PCM);
    check_pair("midframe", ABC_PCM);

    // Reset while the low byte is held
    wait_ready(2200);
    @(posedge clk); #2;
    check("midlo_hi_en", fifo_wr_en, 1);
    fifo_full = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midlo_rst_wr_en", fifo_wr_en, 0);
    check("midlo_rst_wr_data", fifo_wr_data, 0);
    check("midlo_rst_pcm", pcm_out, 0);
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(600);
    check("midlo_pcm", pcm_out, ABC_PCM);
    check_pair("midlo", ABC_PCM);

    check("inst2_frames", pcm2_cnt >= 20, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
